// File: rtl/scroll_pkg.sv
// scroll_pkg: shared types and constants for the running-line scroll sequencer.
//   state_t        : sequencer FSM states (STOP, RUN, STEP)
//   REG_*          : configuration register addresses
//   CTRL_*         : bit positions inside the CTRL register
//   RST_*          : reset defaults (LEN defaults to the H_RES parameter)
package scroll_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   localparam logic [1:0] REG_SPEED = 2'd0;
   localparam logic [1:0] REG_DIV   = 2'd1;
   localparam logic [1:0] REG_LEN   = 2'd2;
   localparam logic [1:0] REG_CTRL  = 2'd3;

   localparam int CTRL_DIR = 0;
   localparam int CTRL_RUN = 1;

   localparam int RST_SPEED = 1;
   localparam int RST_DIV   = 0;
   localparam int RST_CTRL  = 0;

endpackage

// File: rtl/scroll_cfg_regs.sv
// scroll_cfg_regs: double-buffered configuration register file.
// Writes land in the shadow copy only; a commit pulse copies the whole shadow
// set into the active set in one edge, so the sequencer never sees a
// half-updated configuration.
//   clk_pix, rst : pixel clock, asynchronous active-high reset
//   we/addr/wdata: single-cycle shadow write port
//   commit       : copy shadow -> active on this edge (pre-write shadow wins
//                  when a write lands on the same edge)
//   speed/div/len/dir/run : active configuration
module scroll_cfg_regs
   import scroll_pkg::*;
#(
   parameter int H_RES = 640,
   parameter int OFS_W = 12,
   parameter int DIV_W = 8
) (
   input  logic             clk_pix,
   input  logic             rst,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [OFS_W-1:0] wdata,
   input  logic             commit,
   output logic [OFS_W-1:0] speed,
   output logic [DIV_W-1:0] div,
   output logic [OFS_W-1:0] len,
   output logic             dir,
   output logic             run
);

   logic [OFS_W-1:0] speed_shadow_reg, speed_active_reg;
   logic [DIV_W-1:0] div_shadow_reg,   div_active_reg;
   logic [OFS_W-1:0] len_shadow_reg,   len_active_reg;
   logic [1:0]       ctrl_shadow_reg,  ctrl_active_reg;

   always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
         speed_shadow_reg <= OFS_W'(RST_SPEED);
         div_shadow_reg   <= DIV_W'(RST_DIV);
         len_shadow_reg   <= OFS_W'(H_RES);
         ctrl_shadow_reg  <= 2'(RST_CTRL);
      end else if (we) begin
         case (addr)
            REG_SPEED: speed_shadow_reg <= wdata;
            REG_DIV:   div_shadow_reg   <= wdata[DIV_W-1:0];
            REG_LEN:   len_shadow_reg   <= wdata;
            REG_CTRL:  ctrl_shadow_reg  <= wdata[1:0];
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
         speed_active_reg <= OFS_W'(RST_SPEED);
         div_active_reg   <= DIV_W'(RST_DIV);
         len_active_reg   <= OFS_W'(H_RES);
         ctrl_active_reg  <= 2'(RST_CTRL);
      end else if (commit) begin
         speed_active_reg <= speed_shadow_reg;
         div_active_reg   <= div_shadow_reg;
         len_active_reg   <= len_shadow_reg;
         ctrl_active_reg  <= ctrl_shadow_reg;
      end
   end

   assign speed = speed_active_reg;
   assign div   = div_active_reg;
   assign len   = len_active_reg;
   assign dir   = ctrl_active_reg[CTRL_DIR];
   assign run   = ctrl_active_reg[CTRL_RUN];

endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: frame-synchronous scroll sequencer for the running-line display.
// Produces a horizontal offset that only moves during vertical blanking.
//   clk_pix, rst : pixel clock, asynchronous active-high reset
//   sx, sy       : pixel coordinates from the sync generator
//   cfg_we/cfg_addr/cfg_wdata : shadow configuration write port
//   scroll_x     : current offset, in [0, LEN-1] (or 0)
//   frame_tick   : one-cycle pulse per frame, the cycle after (0, V_RES)
//   state        : sequencer state for debug/LEDs
module scroll_ctrl
   import scroll_pkg::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int OFS_W = 12,
   parameter int DIV_W = 8
) (
   input  logic             clk_pix,
   input  logic             rst,
   input  logic [9:0]       sx,
   input  logic [9:0]       sy,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [OFS_W-1:0] cfg_wdata,
   output logic [OFS_W-1:0] scroll_x,
   output logic             frame_tick,
   output logic [1:0]       state
);

   logic             tick_sample;
   logic             tick_reg;
   state_t           state_reg, state_next;
   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic [OFS_W-1:0] ofs_reg, ofs_next;

   logic [OFS_W-1:0] speed, len;
   logic [DIV_W-1:0] div;
   logic             dir, run;

   // First pixel of the first blanking line: commit config and arm the tick.
   assign tick_sample = (sx == 10'd0) && (sy == 10'(V_RES));

   scroll_cfg_regs #(
      .H_RES (H_RES),
      .OFS_W (OFS_W),
      .DIV_W (DIV_W)
   ) u_cfg (
      .clk_pix (clk_pix),
      .rst     (rst),
      .we      (cfg_we),
      .addr    (cfg_addr),
      .wdata   (cfg_wdata),
      .commit  (tick_sample),
      .speed   (speed),
      .div     (div),
      .len     (len),
      .dir     (dir),
      .run     (run)
   );

   // Step arithmetic. Compare/sign decisions use the OFS_W+1 bit value; the
   // final correction can be done modulo 2^OFS_W because the true result
   // always lies in [0, LEN-1] once ofs < LEN and SPEED < LEN.
   logic [OFS_W:0]   sum, diff;
   logic [OFS_W-1:0] n_fwd, n_bwd, step_n;
   logic             step_valid;

   always_comb begin
      sum    = {1'b0, ofs_reg} + {1'b0, speed};
      diff   = {1'b0, ofs_reg} - {1'b0, speed};
      n_fwd  = (sum >= {1'b0, len}) ? (sum[OFS_W-1:0] - len) : sum[OFS_W-1:0];
      n_bwd  = diff[OFS_W] ? (diff[OFS_W-1:0] + len) : diff[OFS_W-1:0];
      step_n = dir ? n_bwd : n_fwd;
   end

   // Degenerate geometry pins the offset to zero and suppresses stepping.
   assign step_valid = (len != '0) && (speed < len);

   always_comb begin
      state_next   = state_reg;
      div_cnt_next = div_cnt_reg;
      case (state_reg)
         STOP: begin
            if (tick_reg && run) begin
               state_next   = RUN;
               div_cnt_next = '0;
            end
         end
         RUN: begin
            if (tick_reg) begin
               if (!run) begin
                  state_next = STOP;
               end else if (div_cnt_reg == div) begin
                  state_next   = STEP;
                  div_cnt_next = '0;
               end else begin
                  div_cnt_next = div_cnt_reg + DIV_W'(1);
               end
            end
         end
         STEP:    state_next = RUN;
         default: state_next = STOP;
      endcase
   end

   // Active config only changes at commit, so this clear fires on the cycle
   // right after a commit that shrinks LEN below the current offset.
   always_comb begin
      ofs_next = ofs_reg;
      if (!step_valid || (len <= ofs_reg)) begin
         ofs_next = '0;
      end else if (state_reg == STEP) begin
         ofs_next = step_n;
      end
   end

   always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
         tick_reg    <= 1'b0;
         state_reg   <= STOP;
         div_cnt_reg <= '0;
         ofs_reg     <= '0;
      end else begin
         tick_reg    <= tick_sample;
         state_reg   <= state_next;
         div_cnt_reg <= div_cnt_next;
         ofs_reg     <= ofs_next;
      end
   end

   assign scroll_x   = ofs_reg;
   assign frame_tick = tick_reg;
   assign state      = state_reg;

endmodule

// File: tb/tb_scroll_ctrl.sv
module tb_scroll_ctrl;
   import scroll_pkg::*;

   localparam int V_RES = 480;

   logic        clk_pix = 1'b0;
   logic        rst;
   logic [9:0]  sx, sy;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [11:0] cfg_wdata;
   logic [11:0] scroll_x;
   logic        frame_tick;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   int tick_cnt = 0;

   scroll_ctrl #(
      .H_RES (640),
      .V_RES (V_RES),
      .OFS_W (12),
      .DIV_W (8)
   ) dut (
      .clk_pix    (clk_pix),
      .rst        (rst),
      .sx         (sx),
      .sy         (sy),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .scroll_x   (scroll_x),
      .frame_tick (frame_tick),
      .state      (state)
   );

   always #5 clk_pix = ~clk_pix;

   always @(negedge clk_pix) if (frame_tick) tick_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [11:0] speed;
      logic [11:0] div;
      logic [11:0] len;
      logic [11:0] ctrl;
      int          frames;
      int          exp_x;
      int          exp_st;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick_edge();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [11:0] d);
      sx = 10'd20; sy = 10'd100;
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick_edge();
      cfg_we = 1'b0;
   endtask

   // Compressed frame: a few active cycles, then the (0, V_RES) sample and
   // enough blanking cycles for the 3-cycle update to finish.
   task automatic run_frame();
      int x0;
      int bad;
      x0 = int'(scroll_x);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         sx = 10'(i + 2); sy = 10'd100;
         tick_edge();
         if (int'(scroll_x) != x0) bad++;
      end
      check("active_stable", bad, 0);
      sx = 10'd0; sy = 10'(V_RES);
      for (int i = 0; i < 6; i++) begin
         tick_edge();
         sx = 10'(i + 1);
      end
      sx = 10'd2; sy = 10'd100;
   endtask

   task automatic active_cycles();
      for (int i = 0; i < 4; i++) begin
         sx = 10'(i + 2); sy = 10'd100;
         tick_edge();
      end
   endtask

   initial begin
      int t0;

      tbl[0]  = '{12'd4,  12'd0, 12'd640, 12'd2, 1, 8,  1};
      tbl[1]  = '{12'd4,  12'd0, 12'd640, 12'd2, 2, 16, 1};
      tbl[2]  = '{12'd2,  12'd0, 12'd640, 12'd3, 1, 14, 1};
      tbl[3]  = '{12'd7,  12'd0, 12'd20,  12'd2, 1, 1,  1};
      tbl[4]  = '{12'd2,  12'd0, 12'd20,  12'd2, 1, 3,  1};
      tbl[5]  = '{12'd7,  12'd0, 12'd20,  12'd3, 1, 16, 1};
      tbl[6]  = '{12'd1,  12'd2, 12'd20,  12'd2, 1, 16, 1};
      tbl[7]  = '{12'd1,  12'd2, 12'd20,  12'd2, 1, 16, 1};
      tbl[8]  = '{12'd1,  12'd2, 12'd20,  12'd2, 1, 17, 1};
      tbl[9]  = '{12'd1,  12'd2, 12'd20,  12'd0, 1, 17, 0};
      tbl[10] = '{12'd1,  12'd2, 12'd20,  12'd0, 2, 17, 0};
      tbl[11] = '{12'd0,  12'd0, 12'd20,  12'd2, 2, 17, 1};
      tbl[12] = '{12'd20, 12'd0, 12'd20,  12'd2, 1, 0,  1};
      tbl[13] = '{12'd3,  12'd0, 12'd0,   12'd2, 1, 0,  1};
      tbl[14] = '{12'd3,  12'd0, 12'd20,  12'd2, 1, 3,  1};
      tbl[15] = '{12'd9,  12'd0, 12'd640, 12'd2, 1, 12, 1};

      rst = 1'b1; sx = 10'd0; sy = 10'd0;
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 12'd0;
      repeat (3) tick_edge();
      check("rst_scroll_x", int'(scroll_x), 0);
      check("rst_frame_tick", int'(frame_tick), 0);
      check("rst_state", int'(state), int'(STOP));
      rst = 1'b0;

      // Default configuration: nothing moves, one tick per frame.
      t0 = tick_cnt;
      repeat (3) run_frame();
      check("default_ticks", tick_cnt - t0, 3);
      check("default_x", int'(scroll_x), 0);
      check("default_state", int'(state), int'(STOP));
      $display("default: 3 frames, scroll_x=%0d state=%0d", scroll_x, state);

      // Start running SPEED=4, then look at the exact update timing.
      write_reg(REG_SPEED, 12'd4);
      write_reg(REG_CTRL, 12'd2);
      run_frame();
      check("start_x", int'(scroll_x), 0);
      check("start_state", int'(state), int'(RUN));
      active_cycles();
      sx = 10'd0; sy = 10'(V_RES);
      tick_edge();
      sx = 10'd1;
      check("t1_tick", int'(frame_tick), 1);
      check("t1_x", int'(scroll_x), 0);
      check("t1_state", int'(state), int'(RUN));
      tick_edge();
      check("t2_tick", int'(frame_tick), 0);
      check("t2_x", int'(scroll_x), 0);
      check("t2_state", int'(state), int'(STEP));
      tick_edge();
      check("t3_x", int'(scroll_x), 4);
      check("t3_state", int'(state), int'(RUN));
      repeat (3) tick_edge();
      $display("timing: scroll_x 0 -> %0d at T+3", scroll_x);

      for (int i = 0; i < 16; i++) begin
         write_reg(REG_SPEED, tbl[i].speed);
         write_reg(REG_DIV,   tbl[i].div);
         write_reg(REG_LEN,   tbl[i].len);
         write_reg(REG_CTRL,  tbl[i].ctrl);
         repeat (tbl[i].frames) run_frame();
         check($sformatf("vec%0d_x", i), int'(scroll_x), tbl[i].exp_x);
         check($sformatf("vec%0d_state", i), int'(state), tbl[i].exp_st);
         $display("vec %0d: speed=%0d div=%0d len=%0d ctrl=%0d frames=%0d -> scroll_x=%0d state=%0d",
                  i, tbl[i].speed, tbl[i].div, tbl[i].len, tbl[i].ctrl, tbl[i].frames,
                  scroll_x, state);
      end

      // LEN=5 written in the tick-sample cycle: deferred by one frame.
      write_reg(REG_SPEED, 12'd0);
      active_cycles();
      sx = 10'd0; sy = 10'(V_RES);
      cfg_we = 1'b1; cfg_addr = REG_LEN; cfg_wdata = 12'd5;
      tick_edge();
      cfg_we = 1'b0; sx = 10'd1;
      repeat (5) tick_edge();
      check("len_deferred_x", int'(scroll_x), 12);
      active_cycles();
      sx = 10'd0; sy = 10'(V_RES);
      tick_edge();
      sx = 10'd1;
      check("len_commit_t1_x", int'(scroll_x), 12);
      tick_edge();
      check("len_clear_t2_x", int'(scroll_x), 0);
      repeat (4) tick_edge();
      check("len_clear_after_x", int'(scroll_x), 0);
      $display("len shrink: scroll_x=%0d", scroll_x);

      // Repeated writes within a frame: the last one wins.
      write_reg(REG_SPEED, 12'd3);
      write_reg(REG_SPEED, 12'd2);
      run_frame();
      check("last_write_x", int'(scroll_x), 2);
      $display("last write: scroll_x=%0d", scroll_x);

      // Asynchronous reset while in STEP.
      active_cycles();
      sx = 10'd0; sy = 10'(V_RES);
      tick_edge();
      sx = 10'd1;
      tick_edge();
      check("pre_rst_state", int'(state), int'(STEP));
      rst = 1'b1;
      #2;
      check("mid_rst_x", int'(scroll_x), 0);
      check("mid_rst_state", int'(state), int'(STOP));
      check("mid_rst_tick", int'(frame_tick), 0);
      rst = 1'b0;
      repeat (3) tick_edge();
      check("post_rst_x", int'(scroll_x), 0);
      write_reg(REG_CTRL, 12'd2);
      run_frame();
      run_frame();
      check("shadow_default_x", int'(scroll_x), 1);
      check("shadow_default_state", int'(state), int'(RUN));
      $display("reset in STEP: scroll_x=%0d state=%0d", scroll_x, state);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
